// File: rtl/asyn_fifo_rd_ctrl.sv
// Read-side controller of an asynchronous FIFO: Gray read pointer, empty flag,
// fill level and a 2-entry output buffer that turns RAM reads into a valid/ready stream.
module asyn_fifo_rd_ctrl #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 4
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic [ASIZE:0]   rq2_wptr,
  output logic             ren,
  output logic [ASIZE-1:0] raddr,
  input  logic [DSIZE-1:0] mem_rdata,
  output logic [ASIZE:0]   rptr,
  output logic             rempty,
  output logic [ASIZE:0]   rlevel,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DSIZE-1:0] m_data
);

  function automatic logic [ASIZE:0] bin2gray(input logic [ASIZE:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [ASIZE:0] gray2bin(input logic [ASIZE:0] g);
    logic [ASIZE:0] b;
    b[ASIZE] = g[ASIZE];
    for (int i = ASIZE - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [ASIZE:0]   rbin;
  logic [ASIZE:0]   rbin_next;
  logic [ASIZE:0]   rgray_next;
  logic [ASIZE:0]   wbin;
  logic             inflight;
  logic [1:0]       buf_cnt;
  logic [1:0]       occ;
  logic             fire;
  logic [DSIZE-1:0] buf0;
  logic [DSIZE-1:0] buf1;

  assign raddr   = rbin[ASIZE-1:0];
  assign m_valid = (buf_cnt != 2'd0);
  assign m_data  = buf0;
  assign fire    = m_valid & m_ready;
  assign occ     = buf_cnt + {1'b0, inflight};

  // Issue a read only when a buffer slot is guaranteed free when the data returns.
  always_comb begin
    ren        = 1'b0;
    wbin       = gray2bin(rq2_wptr);
    if (!rrst && !rempty && ((occ < 2'd2) || fire)) begin
      ren = 1'b1;
    end else begin
      ren = 1'b0;
    end
    rbin_next  = rbin + {{ASIZE{1'b0}}, ren};
    rgray_next = bin2gray(rbin_next);
  end

  // Read pointer, empty flag and level registers.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      rbin     <= '0;
      rptr     <= '0;
      rempty   <= 1'b1;
      rlevel   <= '0;
      inflight <= 1'b0;
    end else begin
      rbin     <= rbin_next;
      rptr     <= rgray_next;
      rempty   <= (rgray_next == rq2_wptr);
      rlevel   <= wbin - rbin_next;
      inflight <= ren;
    end
  end

  // In-order output buffer: capture returning RAM data, pop on handshake.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      buf_cnt <= 2'd0;
      buf0    <= '0;
      buf1    <= '0;
    end else begin
      case ({inflight, fire})
        2'b10: begin
          if (buf_cnt == 2'd0) begin
            buf0 <= mem_rdata;
          end else begin
            buf1 <= mem_rdata;
          end
          buf_cnt <= buf_cnt + 2'd1;
        end
        2'b01: begin
          buf0    <= buf1;
          buf_cnt <= buf_cnt - 2'd1;
        end
        2'b11: begin
          // Pop and append together: count is unchanged.
          if (buf_cnt == 2'd1) begin
            buf0 <= mem_rdata;
          end else begin
            buf0 <= buf1;
            buf1 <= mem_rdata;
          end
        end
        default: begin
          buf_cnt <= buf_cnt;
        end
      endcase
    end
  end

endmodule
